// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage : MEM pipeline stage with a byte-wide data RAM, one scalar     |
// |             byte or one LANES-byte vector per operation, one byte/clk.   |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module mem_stage #(
  parameter int LANES = 20,
  parameter int DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_type,
  input  logic                  op_source,
  input  logic                  write_enable,
  input  logic [31:0]           address,
  input  logic [LANES-1:0][7:0] aluResultV,
  input  logic [LANES-1:0][7:0] rd2_vec,
  input  logic [7:0]            aluResultS,
  input  logic [7:0]            rd2_sca,
  output logic [7:0]            scalar_output,
  output logic [LANES-1:0][7:0] vector_output,
  output logic                  mem_finished,
  output logic [7:0]            mem_data
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = $clog2(LANES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [c_lw-1:0]         r_lane;
  logic [7:0]              r_ram [DEPTH];
  logic [7:0]              r_scalar;
  logic [LANES-1:0][7:0]   r_vector;
  logic                    r_finished;
  logic [7:0]              r_mem_data;

  logic [32:0]             w_end;
  logic                    w_oor;
  logic [c_aw-1:0]         w_idx;
  logic [7:0]              w_rd;
  logic [7:0]              w_src;
  logic                    w_last;

  // Range check at 33 bits so a base near 2^32 cannot wrap back into the RAM.
  assign w_end  = {1'b0, address} + (op_type ? 33'(LANES) : 33'd1) - 33'd1;
  assign w_oor  = (w_end >= 33'(DEPTH));
  assign w_idx  = c_aw'(address) + c_aw'(r_lane);
  assign w_rd   = r_ram[w_idx];
  assign w_src  = op_type ? (op_source ? aluResultV[r_lane] : rd2_vec[r_lane])
                          : (op_source ? aluResultS : rd2_sca);
  assign w_last = !op_type || (r_lane == c_lw'(LANES - 1));

  // RAM sits in the reset-dominated block so no write can occur while rst is low;
  // its contents are deliberately left out of the reset branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_lane     <= '0;
      r_scalar   <= '0;
      r_vector   <= '0;
      r_finished <= 1'b0;
      r_mem_data <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_BUSY: begin
          if (r_state == S_IDLE && w_oor) begin
            r_state    <= S_DONE;
            r_finished <= 1'b1;
            r_mem_data <= '0;
            if (op_type) r_vector <= aluResultV;
            else         r_scalar <= aluResultS;
          end else begin
            if (write_enable)  r_ram[w_idx]     <= w_src;
            else if (op_type)  r_vector[r_lane] <= w_rd;
            r_mem_data <= write_enable ? w_src : w_rd;
            if (w_last) begin
              r_state    <= S_DONE;
              r_finished <= 1'b1;
              if (write_enable) begin
                if (op_type) r_vector <= aluResultV;
                else         r_scalar <= aluResultS;
              end else if (!op_type) begin
                r_scalar <= w_rd;
              end
            end else begin
              r_state <= S_BUSY;
              r_lane  <= r_lane + c_lw'(1);
            end
          end
        end
        S_DONE: begin
          r_mem_data <= '0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign scalar_output = r_scalar;
  assign vector_output = r_vector;
  assign mem_finished  = r_finished;
  assign mem_data      = r_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_stage : scoreboard bench for mem_stage with a byte-array RAM model|
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_mem_stage;

  localparam int LANES = 20;
  localparam int DEPTH = 256;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  op_type = 1'b0;
  logic                  op_source = 1'b0;
  logic                  write_enable = 1'b0;
  logic [31:0]           address = '0;
  logic [LANES-1:0][7:0] aluResultV = '0;
  logic [LANES-1:0][7:0] rd2_vec = '0;
  logic [7:0]            aluResultS = '0;
  logic [7:0]            rd2_sca = '0;
  logic [7:0]            scalar_output;
  logic [LANES-1:0][7:0] vector_output;
  logic                  mem_finished;
  logic [7:0]            mem_data;

  mem_stage #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .op_type(op_type), .op_source(op_source),
    .write_enable(write_enable), .address(address), .aluResultV(aluResultV),
    .rd2_vec(rd2_vec), .aluResultS(aluResultS), .rd2_sca(rd2_sca),
    .scalar_output(scalar_output), .vector_output(vector_output),
    .mem_finished(mem_finished), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]            sca;
    logic [LANES-1:0][7:0] vec;
    int                    lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] md_q[$];
  logic [7:0] mram [DEPTH];
  int         errors = 0;
  int         checks = 0;

  int   cyc = 0;
  bit   fin_seen = 0;
  bit   op_done = 0;
  bit   have_last = 0;
  exp_t last_e;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=event required=none (cyc=%0d)", name, cyc);
  endtask

  // Monitor: consumes expected trace bytes every cycle and the result at completion.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      cyc = 0; fin_seen = 0; op_done = 0; have_last = 0;
    end else begin
      cyc++;
      if (!fin_seen) begin
        if (md_q.size() == 0) fail_now("mem_data_extra");
        else check("mem_data", 160'(mem_data), 160'(md_q.pop_front()));
        if (mem_finished) begin
          fin_seen = 1; op_done = 1;
          if (exp_q.size() == 0) fail_now("unexpected_finish");
          else begin
            e = exp_q.pop_front();
            check("latency", 160'(cyc), 160'(e.lat));
            check("scalar_output", 160'(scalar_output), 160'(e.sca));
            check("vector_output", vector_output, e.vec);
            last_e = e; have_last = 1;
          end
          if (md_q.size() != 0) begin fail_now("mem_data_missing"); md_q.delete(); end
        end else if (cyc > 40) begin
          fail_now("finish_timeout");
          fin_seen = 1; op_done = 1;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          md_q.delete();
        end
      end else if (have_last) begin
        check("sticky_finished", 160'(mem_finished), 160'(1));
        check("done_mem_data", 160'(mem_data), 160'(0));
        check("sticky_outputs", {vector_output[LANES-1:1], scalar_output},
              {last_e.vec[LANES-1:1], last_e.sca});
      end
    end
  end

  // Runs one operation; abort_lanes >= 0 asserts reset after that many lanes.
  task automatic run_op(input logic t, input logic s, input logic we,
                        input logic [31:0] a, input int abort_lanes);
    exp_t        e;
    int          n;
    logic [63:0] last;
    logic [7:0]  b;
    int          ad;
    @(negedge clk); #1;
    rst = 1'b0;
    op_type = t; op_source = s; write_enable = we; address = a;
    #1;
    check("reset_outputs", {vector_output, scalar_output, mem_data, 7'd0, mem_finished}, '0);
    n = t ? LANES : 1;
    last = 64'(a) + 64'(n) - 64'd1;
    e.sca = '0; e.vec = '0; e.lat = 1;
    if (last >= 64'(DEPTH)) begin
      if (t) e.vec = aluResultV; else e.sca = aluResultS;
      md_q.push_back(8'd0);
    end else begin
      e.lat = n;
      for (int k = 0; k < n; k++) begin
        if (abort_lanes >= 0 && k >= abort_lanes) break;
        ad = int'(a) + k;
        if (we) begin
          b = t ? (s ? aluResultV[k] : rd2_vec[k]) : (s ? aluResultS : rd2_sca);
          mram[ad] = b;
        end else begin
          b = mram[ad];
          if (t) e.vec[k] = b; else e.sca = b;
        end
        md_q.push_back(b);
      end
      if (we) begin
        if (t) e.vec = aluResultV; else e.sca = aluResultS;
      end
    end
    if (abort_lanes < 0) exp_q.push_back(e);
    @(negedge clk); #1;
    rst = 1'b1;
    if (abort_lanes >= 0) begin
      repeat (abort_lanes) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_outputs", {vector_output, scalar_output, mem_data, 7'd0, mem_finished}, '0);
    end else begin
      for (int i = 0; i < 45 && !op_done; i++) @(negedge clk);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < LANES; i++) begin
      aluResultV[i] = 8'($urandom);
      rd2_vec[i]    = 8'($urandom);
    end
    aluResultS = 8'($urandom);
    rd2_sca    = 8'($urandom);
  endtask

  initial begin
    int          r;
    logic [31:0] a;
    logic        t;
    for (int i = 0; i < DEPTH; i++) mram[i] = 8'd0;

    // Give every RAM byte a known value.
    for (int base = 0; base <= DEPTH - LANES; base += LANES) begin
      rand_data(); run_op(1'b1, 1'b0, 1'b1, 32'(base), -1);
    end
    rand_data(); run_op(1'b1, 1'b0, 1'b1, 32'(DEPTH - LANES), -1);

    // Vector store/load from register operand.
    for (int i = 0; i < LANES; i++) rd2_vec[i] = 8'(100 + i);
    run_op(1'b1, 1'b0, 1'b1, 32'd0, -1);
    rand_data(); run_op(1'b1, 1'b0, 1'b0, 32'd0, -1);

    // Vector store from ALU result.
    for (int i = 0; i < LANES; i++) aluResultV[i] = 8'(50 + i);
    run_op(1'b1, 1'b1, 1'b1, 32'd20, -1);
    run_op(1'b1, 1'b0, 1'b0, 32'd20, -1);

    // Scalar store/load.
    aluResultS = 8'd40;
    run_op(1'b0, 1'b1, 1'b1, 32'd5, -1);
    aluResultS = 8'd7;
    run_op(1'b0, 1'b0, 1'b0, 32'd5, -1);

    // Out of range passes ALU result through, RAM untouched.
    for (int i = 0; i < LANES; i++) aluResultV[i] = 8'(50 + i);
    run_op(1'b1, 1'b0, 1'b0, 32'h0000FFFF, -1);
    run_op(1'b1, 1'b1, 1'b1, 32'(DEPTH - LANES + 1), -1);
    run_op(1'b1, 1'b0, 1'b0, 32'd0, -1);

    // Boundaries, including bases that would wrap at 32 bits.
    run_op(1'b1, 1'b0, 1'b0, 32'(DEPTH - LANES), -1);
    run_op(1'b1, 1'b0, 1'b0, 32'(DEPTH - LANES + 1), -1);
    rand_data(); run_op(1'b0, 1'b0, 1'b1, 32'(DEPTH - 1), -1);
    run_op(1'b0, 1'b0, 1'b0, 32'(DEPTH - 1), -1);
    run_op(1'b0, 1'b1, 1'b1, 32'(DEPTH), -1);
    run_op(1'b1, 1'b0, 1'b1, 32'hFFFFFFF0, -1);
    run_op(1'b1, 1'b0, 1'b0, 32'(DEPTH - LANES), -1);

    // Reset at lane 7 of a store.
    for (int i = 0; i < LANES; i++) rd2_vec[i] = 8'(200 + i);
    run_op(1'b1, 1'b0, 1'b1, 32'd40, 7);
    run_op(1'b1, 1'b0, 1'b0, 32'd40, -1);

    // Randomized mix.
    for (int j = 0; j < 40; j++) begin
      rand_data();
      t = 1'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'($urandom_range(0, t ? DEPTH - LANES : DEPTH - 1));
      else if (r == 7) a = 32'(t ? DEPTH - LANES : DEPTH - 1) + 32'($urandom_range(0, 1));
      else if (r == 8) a = $urandom;
      else             a = 32'hFFFFFFFF - 32'($urandom_range(0, 25));
      run_op(t, 1'($urandom), 1'($urandom), a, -1);
    end

    if (exp_q.size() != 0) fail_now("pending_results");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
